// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM state encoding, memory geometry,
// CPU opcode names and the checksum helper.
package prog_loader_pkg;

  localparam int PL_MEM_DEPTH = 32;
  localparam int PL_ADDR_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } pl_state_e;

  typedef enum logic [7:0] {
    OP_NOP  = 8'h00,
    OP_LDI  = 8'hA0,
    OP_ADD  = 8'hC2,
    OP_HALT = 8'hFF
  } pl_opcode_e;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/prog_run_monitor.sv
// RUN-phase supervisor: counts RUN cycles (1 in the first RUN cycle), detects
// halt or timeout, and captures the CPU program counter when either occurs.
module prog_run_monitor
  import prog_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 clr_i,
  input  logic                 enter_i,
  input  logic                 run_i,
  input  logic                 halt_i,
  input  logic [PL_ADDR_W-1:0] pc_addr_i,
  output logic                 stop_o,
  output logic [CNT_W-1:0]     run_cycles_o,
  output logic                 halted_o,
  output logic                 timeout_o,
  output logic [PL_ADDR_W-1:0] final_pc_o
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 halted_q, halted_d;
  logic                 timeout_q, timeout_d;
  logic [PL_ADDR_W-1:0] fpc_q, fpc_d;
  logic                 to_hit;

  assign to_hit = (cnt_q >= TO_LIM);
  assign stop_o = run_i && (halt_i || to_hit);

  // Halt has priority over timeout when both land in the same cycle.
  always_comb begin
    cnt_d     = cnt_q;
    halted_d  = halted_q;
    timeout_d = timeout_q;
    fpc_d     = fpc_q;
    if (clr_i) begin
      cnt_d     = '0;
      halted_d  = 1'b0;
      timeout_d = 1'b0;
      fpc_d     = '0;
    end else if (enter_i) begin
      cnt_d = CNT_W'(1);
    end else if (run_i) begin
      if (halt_i) begin
        halted_d = 1'b1;
        fpc_d    = pc_addr_i;
      end else if (to_hit) begin
        timeout_d = 1'b1;
        fpc_d     = pc_addr_i;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q     <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      fpc_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
      fpc_q     <= fpc_d;
    end
  end

  assign run_cycles_o = cnt_q;
  assign halted_o     = halted_q;
  assign timeout_o    = timeout_q;
  assign final_pc_o   = fpc_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: clears CPU program memory, streams a program in, releases
// the CPU from reset and supervises the run. Define PROG_LOADER_CSUM_EN to
// treat the s_last beat as a modulo-256 checksum byte instead of program data.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MEM_DEPTH      = PL_MEM_DEPTH,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic                 s_last,
  output logic [PL_ADDR_W-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_wr,
  output logic                 cpu_rst_,
  input  logic                 halt,
  input  logic [PL_ADDR_W-1:0] pc_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 halted,
  output logic                 timeout,
  output logic                 err_len,
  output logic                 err_csum,
  output logic [PL_ADDR_W-1:0] final_pc,
  output logic [CNT_W-1:0]     run_cycles
);

  // One extra bit lets the counter express "MEM_DEPTH bytes written" without wrapping.
  localparam int CW = PL_ADDR_W + 1;
  localparam logic [CW-1:0] LAST_A = CW'(MEM_DEPTH - 1);
  localparam logic [CW-1:0] FULL_A = CW'(MEM_DEPTH);

  pl_state_e     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_len_q, err_len_d;
  logic          clr, enter, stop;

`ifdef PROG_LOADER_CSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       err_csum_q, err_csum_d;
`endif

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    err_len_d = err_len_q;
    clr       = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    s_ready   = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
    csum_d     = csum_q;
    err_csum_d = err_csum_q;
`endif
    case (st_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          st_d      = ST_CLEAR;
          cnt_d     = '0;
          err_len_d = 1'b0;
          clr       = 1'b1;
`ifdef PROG_LOADER_CSUM_EN
          csum_d     = 8'h00;
          err_csum_d = 1'b0;
`endif
        end
      end
      ST_CLEAR: begin
        mem_wr = 1'b1;
        if (cnt_q == LAST_A) begin
          st_d  = ST_LOAD;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
`ifdef PROG_LOADER_CSUM_EN
          if (s_last) begin
            if (s_data == csum_q) begin
              st_d = ST_RUN;
            end else begin
              err_csum_d = 1'b1;
              st_d       = ST_DONE;
            end
          end else if (cnt_q == FULL_A) begin
            err_len_d = 1'b1;
            st_d      = ST_DONE;
          end else begin
            mem_wr    = 1'b1;
            mem_wdata = s_data;
            csum_d    = csum_add(csum_q, s_data);
            cnt_d     = cnt_q + CW'(1);
          end
`else
          if (cnt_q == FULL_A) begin
            err_len_d = 1'b1;
            st_d      = ST_DONE;
          end else begin
            mem_wr    = 1'b1;
            mem_wdata = s_data;
            cnt_d     = cnt_q + CW'(1);
            if (s_last) st_d = ST_RUN;
          end
`endif
        end
      end
      ST_RUN: begin
        if (stop) st_d = ST_DONE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  assign enter = (st_d == ST_RUN) && (st_q != ST_RUN);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      err_len_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      err_len_q <= err_len_d;
    end
  end

`ifdef PROG_LOADER_CSUM_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      csum_q     <= 8'h00;
      err_csum_q <= 1'b0;
    end else begin
      csum_q     <= csum_d;
      err_csum_q <= err_csum_d;
    end
  end
  assign err_csum = err_csum_q;
`else
  assign err_csum = 1'b0;
`endif

  prog_run_monitor #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_mon (
    .clk         (clk),
    .rst_        (rst_),
    .clr_i       (clr),
    .enter_i     (enter),
    .run_i       (st_q == ST_RUN),
    .halt_i      (halt),
    .pc_addr_i   (pc_addr),
    .stop_o      (stop),
    .run_cycles_o(run_cycles),
    .halted_o    (halted),
    .timeout_o   (timeout),
    .final_pc_o  (final_pc)
  );

  assign mem_addr = cnt_q[PL_ADDR_W-1:0];
  assign cpu_rst_ = (st_q == ST_RUN);
  assign busy     = (st_q == ST_CLEAR) || (st_q == ST_LOAD) || (st_q == ST_RUN);
  assign done     = (st_q == ST_DONE);
  assign err_len  = err_len_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued as
// stimulus is issued and checked by a write monitor; status is checked inline.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_, start, s_valid, s_last, halt;
  logic [7:0]  s_data;
  logic [4:0]  pc_addr;
  logic        s_ready, mem_wr, cpu_rst_, busy, done, halted, timeout, err_len, err_csum;
  logic [4:0]  mem_addr, final_pc;
  logic [7:0]  mem_wdata;
  logic [15:0] run_cycles;

  int n_chk  = 0;
  int n_fail = 0;

  logic [12:0] exp_q[$];
  logic [7:0]  byte_q[$];
  logic [12:0] exp_e;

  prog_loader #(
    .MEM_DEPTH     (32),
    .TIMEOUT_CYCLES(100),
    .CNT_W         (16)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .start     (start),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .cpu_rst_  (cpu_rst_),
    .halt      (halt),
    .pc_addr   (pc_addr),
    .busy      (busy),
    .done      (done),
    .halted    (halted),
    .timeout   (timeout),
    .err_len   (err_len),
    .err_csum  (err_csum),
    .final_pc  (final_pc),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Write monitor: every memory write must match the head of the expected queue.
  always @(negedge clk) begin
    if (mem_wr) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr=%0d data=%02h, required no write", mem_addr, mem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp_e) begin
          n_fail++;
          $display("FAIL wr: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   mem_addr, mem_wdata, exp_e[12:8], exp_e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), 8'h00});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    bit acc;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL handshake_timeout: got s_ready=0 for 200 cycles, required 1");
    end
  endtask

`ifdef PROG_LOADER_CSUM_EN
  logic [7:0] csum_adj = 8'h00;
`endif

  task automatic send_prog(input bit use_last);
    logic [7:0] sum;
    logic       last;
    sum = 8'h00;
    for (int i = 0; i < byte_q.size(); i++) begin
      last = use_last && (i == byte_q.size() - 1);
`ifdef PROG_LOADER_CSUM_EN
      last = 1'b0;
`endif
      if (i < 32) exp_q.push_back({5'(i), byte_q[i]});
      sum = sum + byte_q[i];
      send_beat(byte_q[i], last);
    end
`ifdef PROG_LOADER_CSUM_EN
    if (use_last) send_beat(sum + csum_adj, 1'b1);
`endif
  endtask

  // Called in the first RUN cycle; halt is raised in the n-th RUN cycle.
  task automatic run_halt(input int n, input logic [4:0] pc);
    for (int k = 1; k < n; k++) begin
      @(posedge clk); #1;
    end
    halt    = 1'b1;
    pc_addr = pc;
    @(posedge clk); #1;
    halt = 1'b0;
  endtask

  // Runs 100 RUN cycles with pc_addr = cycle number; optional halt on the 100th.
  task automatic run_to_limit(input logic hlt);
    for (int k = 1; k <= 100; k++) begin
      pc_addr = 5'(k);
      halt    = hlt && (k == 100);
      @(posedge clk); #1;
    end
    halt = 1'b0;
  endtask

  initial begin
    rst_ = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    halt = 1'b0; pc_addr = 5'd0;
    repeat (2) @(posedge clk); #1;
    chk("rst_cpu_rst", 32'(cpu_rst_), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_flags", 32'({halted, timeout, err_len, err_csum}), 0);
    chk("rst_final_pc", 32'(final_pc), 0);
    chk("rst_run_cycles", 32'(run_cycles), 0);
    rst_ = 1'b1;
    @(posedge clk); #1;

    // Normal load and halt after 40 RUN cycles
    do_start();
    chk("clear_busy", 32'(busy), 1);
    chk("clear_cpu_rst", 32'(cpu_rst_), 0);
    chk("clear_s_ready", 32'(s_ready), 0);
    byte_q = '{8'hA0, 8'h01, 8'hC2, 8'h00};
    send_prog(1'b1);
    chk("run_cpu_rst", 32'(cpu_rst_), 1);
    chk("run_first_cnt", 32'(run_cycles), 1);
    chk("run_busy", 32'(busy), 1);
    run_halt(40, 5'd7);
    chk("halt_halted", 32'(halted), 1);
    chk("halt_timeout", 32'(timeout), 0);
    chk("halt_run_cycles", 32'(run_cycles), 40);
    chk("halt_final_pc", 32'(final_pc), 7);
    chk("halt_done", 32'(done), 1);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_cpu_rst", 32'(cpu_rst_), 0);
    chk("halt_err_csum", 32'(err_csum), 0);

    // Overlong stream: 33 beats without s_last
    do_start();
    chk("restart_done_cleared", 32'(done), 0);
    chk("restart_halted_cleared", 32'(halted), 0);
    byte_q.delete();
    for (int i = 0; i < 33; i++) byte_q.push_back(8'(i + 1));
    send_prog(1'b0);
    chk("len_err_len", 32'(err_len), 1);
    chk("len_done", 32'(done), 1);
    chk("len_cpu_rst", 32'(cpu_rst_), 0);
    chk("len_run_cycles", 32'(run_cycles), 0);

    // Timeout with halt never asserted
    do_start();
    chk("restart_err_len_cleared", 32'(err_len), 0);
    byte_q = '{8'hA0};
    send_prog(1'b1);
    run_to_limit(1'b0);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_halted", 32'(halted), 0);
    chk("to_run_cycles", 32'(run_cycles), 100);
    chk("to_final_pc", 32'(final_pc), 4);
    chk("to_done", 32'(done), 1);

    // Halt in the timeout cycle wins
    do_start();
    byte_q = '{8'h3C};
    send_prog(1'b1);
    run_to_limit(1'b1);
    chk("both_halted", 32'(halted), 1);
    chk("both_timeout", 32'(timeout), 0);
    chk("both_run_cycles", 32'(run_cycles), 100);
    chk("both_final_pc", 32'(final_pc), 4);

`ifdef PROG_LOADER_CSUM_EN
    do_start();
    byte_q = '{8'h10, 8'h20};
    csum_adj = 8'h00;
    send_prog(1'b1);
    chk("csum_ok_run", 32'(cpu_rst_), 1);
    chk("csum_ok_err", 32'(err_csum), 0);
    run_halt(1, 5'd2);
    do_start();
    csum_adj = 8'h01;
    send_prog(1'b1);
    chk("csum_bad_err", 32'(err_csum), 1);
    chk("csum_bad_done", 32'(done), 1);
    chk("csum_bad_cpu_rst", 32'(cpu_rst_), 0);
    chk("csum_bad_run_cycles", 32'(run_cycles), 0);
    csum_adj = 8'h00;
`endif

    // Reset during LOAD with s_valid held high
    do_start();
    byte_q = '{8'h55, 8'h66};
    send_prog(1'b0);
    s_valid = 1'b1;
    s_data  = 8'h77;
    rst_    = 1'b0;
    #1;
    chk("midrst_mem_wr", 32'(mem_wr), 0);
    chk("midrst_s_ready", 32'(s_ready), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_mem_addr", 32'(mem_addr), 0);
    repeat (2) @(posedge clk); #1;
    rst_ = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("midrst_idle_busy", 32'(busy), 0);
    chk("midrst_idle_done", 32'(done), 0);
    chk("midrst_idle_ready", 32'(s_ready), 0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("writes_outstanding", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
